axil_apb_bridge_mc: RTL and testbench
=====================================

// Module: axil_apb_bridge_mc
// PURPOSE
//  Parametrised AXI4-Lite slave to multi-slave APB master bridge.
//  - Address decode into N equal regions; AW/W/AR capture buffers.
//  - Fair read/write arbitration, PSTRB/PPROT pass-through.
//  - Per-transfer timeout, SLVERR/DECERR reporting.
//  Sits between the AXI4-Lite interconnect and the APB peripheral cluster.
// PARAMETERS
//  C_APB_NUM_SLAVES  4             number of APB slaves, 1..16
//  ADDR_WIDTH        32            AXI/APB address width
//  DATA_WIDTH        32            data width, 32 only (PSTRB = DATA_WIDTH/8)
//  BASE_ADDR         32'h0000_0000 base of decoded window
//  SLAVE_SPAN        32'h0000_1000 bytes per slave region, power of 2
//  TIMEOUT_VAL       16            ACCESS cycles before abort; 0 = disabled
// PORTS
//  s_axi_clk      in  1     single clock for AXI and APB
//  s_axi_areset   in  1     asynchronous reset, active-high
//  s_axi_awaddr/awprot/awvalid in AW/3/1; s_axi_awready out 1
//  s_axi_wdata/wstrb/wvalid    in DW/DW/8/1; s_axi_wready out 1
//  s_axi_bresp/bvalid          out 2/1; s_axi_bready in 1
//  s_axi_araddr/arprot/arvalid in AW/3/1; s_axi_arready out 1
//  s_axi_rdata/rresp/rvalid    out DW/2/1; s_axi_rready in 1
//  m_apb_paddr    out AW    transfer address
//  m_apb_pprot    out 3     awprot or arprot of the granted request
//  m_apb_psel     out N     one-hot slave select
//  m_apb_penable  out 1     ACCESS phase
//  m_apb_pwrite   out 1     1 = write
//  m_apb_pwdata   out DW    write data
//  m_apb_pstrb    out DW/8  wstrb on write, 0 on read
//  m_apb_pready   in  N     per-slave ready
//  m_apb_prdata   in  N*DW  flat; slave i at [i*DW +: DW]
//  m_apb_pslverr  in  N     per-slave error
// BEHAVIOUR
//  - Reset: every output 0, buffers empty, FSM IDLE, read has priority.
//    Mid-transfer reset aborts immediately; no response issued.
//  - Capture: AW, W, AR each hold one entry.
//    awready=!aw_full, wready=!w_full, arready=!ar_full.
//    Readies go 1 on the first cycle after reset. An entry clears on its
//    B/R handshake. A write is pending only when both AW and W are full.
//  - Arbitration in IDLE: if only one is pending, grant it. If both,
//    grant opposite of last served (toggle on each grant).
//  - Decode: off = addr-BASE_ADDR; idx = off/SLAVE_SPAN.
//    If addr<BASE_ADDR or idx>=N: DECERR (2'b11), no APB activity,
//    go IDLE->RESP, rdata=0.
//  - FSM IDLE->SETUP->ACCESS->RESP->IDLE.
//    SETUP (1 cycle): psel[idx]=1, penable=0; paddr, pwrite, pwdata,
//    pstrb, pprot driven.
//    ACCESS: penable=1; all APB outputs stable until exit.
//    Exit on pready[idx]: capture prdata slice; resp=pslverr[idx]?2'b10:2'b00.
//    RESP: bvalid or rvalid held with stable resp/rdata until
//    bready/rready, then IDLE and buffer clears. psel/penable=0 outside
//    SETUP/ACCESS; pready/pslverr of non-selected slaves ignored.
//  - Timeout: counter loads TIMEOUT_VAL on SETUP->ACCESS and decrements on
//    every ACCESS cycle with pready[idx]=0. At 0: drop psel/penable,
//    resp=SLVERR, rdata=0, go RESP. pready on the expiry cycle still wins.
//  - Latency: accepted AR at cycle 0 -> SETUP c1, ACCESS c2; pready at c2
//    -> rvalid c3. One transaction outstanding.
// TESTING
//  - Read, N=4, addr 0x1004, pready[1]=1 in first ACCESS,
//    prdata slice1=0xDEADBEEF -> psel=4'b0010 c1-c2,
//    rvalid c3, rdata=0xDEADBEEF, rresp=00.
//  - Write 0x3008, data 0x12345678, wstrb 4'b0101, W arriving 3 cycles
//    after AW -> no SETUP until W; pstrb=0101, psel=1000, bresp=00.
//  - AR and AW+W valid same cycle after reset -> read served first,
//    then write; then two more of each alternate write, read.
//  - addr 0x5000 (idx 5 >= 4) -> no psel, bresp=11; pslverr=1 on slave
//    2 -> rresp=10.
//  - TIMEOUT_VAL=16, pready held 0 -> penable drops after 16 ACCESS
//    cycles, rresp=10, rdata=0.
//  - Reset asserted in ACCESS -> psel/penable/rvalid 0 at once, buffers
//    empty, readies 1 after release.

Source files
------------

// File: rtl/axil_apb_bridge_mc.sv
// AXI4-Lite slave to multi-slave APB master bridge: one outstanding transfer,
// address decode into equal regions, read/write alternation and ACCESS timeout.
module axil_apb_bridge_mc #(
  parameter int unsigned            C_APB_NUM_SLAVES = 4,
  parameter int unsigned            ADDR_WIDTH       = 32,
  parameter int unsigned            DATA_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR        = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0]  SLAVE_SPAN       = 32'h0000_1000,
  parameter int unsigned            TIMEOUT_VAL      = 16
) (
  input  logic                                   s_axi_clk,
  input  logic                                   s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_awaddr,
  input  logic [2:0]                             s_axi_awprot,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                  s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]                s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_araddr,
  input  logic [2:0]                             s_axi_arprot,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [DATA_WIDTH-1:0]                  s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic [ADDR_WIDTH-1:0]                  m_apb_paddr,
  output logic [2:0]                             m_apb_pprot,
  output logic [C_APB_NUM_SLAVES-1:0]            m_apb_psel,
  output logic                                   m_apb_penable,
  output logic                                   m_apb_pwrite,
  output logic [DATA_WIDTH-1:0]                  m_apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]                m_apb_pstrb,
  input  logic [C_APB_NUM_SLAVES-1:0]            m_apb_pready,
  input  logic [C_APB_NUM_SLAVES*DATA_WIDTH-1:0] m_apb_prdata,
  input  logic [C_APB_NUM_SLAVES-1:0]            m_apb_pslverr
);

  localparam int unsigned N       = C_APB_NUM_SLAVES;
  localparam int unsigned SW      = DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SPAN_SH = $clog2(SLAVE_SPAN);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                 state_q;
  logic                   aw_full_q, w_full_q, ar_full_q;
  logic                   aw_full_d, w_full_d, ar_full_d;
  logic                   awready_q, wready_q, arready_q;
  logic [ADDR_WIDTH-1:0]  aw_addr_q, ar_addr_q;
  logic [2:0]             aw_prot_q, ar_prot_q;
  logic [DATA_WIDTH-1:0]  w_data_q;
  logic [SW-1:0]          w_strb_q;
  logic                   last_wr_q, cur_wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            cnt_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [2:0]             pprot_q;
  logic [N-1:0]           psel_q;
  logic                   penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q, rdata_q;
  logic [SW-1:0]          pstrb_q;
  logic                   bvalid_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;

  logic                   aw_hs_s, w_hs_s, ar_hs_s, b_done_s, r_done_s;
  logic                   rd_pend_s, wr_pend_s, grant_rd_s;
  logic [ADDR_WIDTH-1:0]  req_addr_s, off_s, slot_s;
  logic [2:0]             req_prot_s;
  logic                   dec_err_s;
  logic [IDX_W-1:0]       dec_idx_s;
  logic                   pready_sel_s, pslverr_sel_s;
  logic [DATA_WIDTH-1:0]  prdata_sel_s;

  // Handshakes, buffer next-state, arbitration and address decode
  always_comb begin
    aw_hs_s      = s_axi_awvalid & awready_q;
    w_hs_s       = s_axi_wvalid & wready_q;
    ar_hs_s      = s_axi_arvalid & arready_q;
    b_done_s     = bvalid_q & s_axi_bready;
    r_done_s     = rvalid_q & s_axi_rready;
    aw_full_d    = aw_hs_s | (aw_full_q & ~b_done_s);
    w_full_d     = w_hs_s | (w_full_q & ~b_done_s);
    ar_full_d    = ar_hs_s | (ar_full_q & ~r_done_s);
    rd_pend_s    = ar_full_q;
    wr_pend_s    = aw_full_q & w_full_q;
    // Under contention the request type not served last time wins.
    grant_rd_s   = rd_pend_s & (~wr_pend_s | last_wr_q);
    req_addr_s   = grant_rd_s ? ar_addr_q : aw_addr_q;
    req_prot_s   = grant_rd_s ? ar_prot_q : aw_prot_q;
    off_s        = req_addr_s - BASE_ADDR;
    slot_s       = off_s >> SPAN_SH;
    dec_err_s    = (req_addr_s < BASE_ADDR) | (slot_s >= ADDR_WIDTH'(N));
    dec_idx_s    = slot_s[IDX_W-1:0];
    pready_sel_s  = m_apb_pready[idx_q];
    pslverr_sel_s = m_apb_pslverr[idx_q];
    prdata_sel_s  = m_apb_prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  end

  // AW/W/AR single-entry capture buffers and their registered readies
  always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= 3'b000;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      ar_prot_q <= 3'b000;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~ar_full_d;
      if (aw_hs_s) begin
        aw_addr_q <= s_axi_awaddr;
        aw_prot_q <= s_axi_awprot;
      end
      if (w_hs_s) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (ar_hs_s) begin
        ar_addr_q <= s_axi_araddr;
        ar_prot_q <= s_axi_arprot;
      end
    end
  end

  // Transfer FSM with registered APB and AXI response outputs
  always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b1;
      cur_wr_q  <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= 32'd0;
      paddr_q   <= '0;
      pprot_q   <= 3'b000;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_pend_s | wr_pend_s) begin
            last_wr_q <= ~grant_rd_s;
            cur_wr_q  <= ~grant_rd_s;
            if (dec_err_s) begin
              state_q <= S_RESP;
              if (grant_rd_s) begin
                rvalid_q <= 1'b1;
                rresp_q  <= 2'b11;
                rdata_q  <= '0;
              end else begin
                bvalid_q <= 1'b1;
                bresp_q  <= 2'b11;
              end
            end else begin
              state_q  <= S_SETUP;
              idx_q    <= dec_idx_s;
              psel_q   <= N'(1) << dec_idx_s;
              paddr_q  <= req_addr_s;
              pprot_q  <= req_prot_s;
              pwrite_q <= ~grant_rd_s;
              pwdata_q <= grant_rd_s ? '0 : w_data_q;
              pstrb_q  <= grant_rd_s ? '0 : w_strb_q;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= 32'(TIMEOUT_VAL);
        end
        S_ACCESS: begin
          // A slave answering on the expiry cycle takes precedence over the abort.
          if (pready_sel_s) begin
            state_q   <= S_RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (cur_wr_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= pslverr_sel_s ? 2'b10 : 2'b00;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= pslverr_sel_s ? 2'b10 : 2'b00;
              rdata_q  <= prdata_sel_s;
            end
          end else if ((TIMEOUT_VAL != 0) && (cnt_q == 32'd1)) begin
            state_q   <= S_RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (cur_wr_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b10;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= 2'b10;
              rdata_q  <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_RESP: begin
          if (cur_wr_q ? s_axi_bready : s_axi_rready) begin
            state_q  <= S_IDLE;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pprot   = pprot_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_axil_apb_bridge_mc.sv
// Scoreboard bench for axil_apb_bridge_mc: expected APB setups and B/R
// responses are queued by the stimulus and popped by independent monitors.
module tb_axil_apb_bridge_mc;

  localparam logic [31:0] SD0 = 32'hA0A0_0000;
  localparam logic [31:0] SD1 = 32'hDEAD_BEEF;
  localparam logic [31:0] SD2 = 32'hC2C2_2222;
  localparam logic [31:0] SD3 = 32'hD3D3_3333;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
  logic [2:0]   awprot = 3'd0, arprot = 3'd0;
  logic [3:0]   wstrb = 4'd0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic         awready, wready, arready, bvalid, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, paddr, pwdata;
  logic [2:0]   pprot;
  logic [3:0]   psel, pstrb, pready, pslverr;
  logic         penable, pwrite;
  logic [127:0] prdata;

  int           ready_delay = 0;
  int           acc_cnt = 0;
  logic [3:0]   err_mask = 4'b0000;
  int           errors = 0;
  int           checks = 0;

  typedef struct packed {
    logic [3:0]  psel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_t;
  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  apb_t apb_q[$];
  rsp_t r_q[$];
  rsp_t b_q[$];

  always #5 clk = ~clk;

  axil_apb_bridge_mc dut (
    .s_axi_clk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .m_apb_paddr(paddr), .m_apb_pprot(pprot), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_pready(pready), .m_apb_prdata(prdata), .m_apb_pslverr(pslverr)
  );

  // APB slave model: ready after ready_delay ACCESS cycles, error lines driven unmasked
  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;
  assign pready  = psel & {4{penable && (acc_cnt >= ready_delay)}};
  assign pslverr = err_mask;
  assign prdata  = {SD3, SD2, SD1, SD0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_apb(input logic [3:0] ps, input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    apb_t e;
    e.psel = ps; e.addr = a; e.wr = w; e.wdata = d; e.strb = s; e.prot = p;
    apb_q.push_back(e);
  endfunction

  function automatic void exp_r(input logic [1:0] rs, input logic [31:0] d);
    rsp_t e;
    e.resp = rs; e.data = d;
    r_q.push_back(e);
  endfunction

  function automatic void exp_b(input logic [1:0] rs);
    rsp_t e;
    e.resp = rs; e.data = 32'd0;
    b_q.push_back(e);
  endfunction

  // APB monitor: every SETUP phase must match the next queued transfer
  always @(negedge clk) begin
    apb_t e;
    if (!rst && psel != 4'b0000 && !penable) begin
      if (apb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apb_unexpected: psel=%b paddr=%h, expected no transfer", psel, paddr);
      end else begin
        e = apb_q.pop_front();
        check("psel", 32'(psel), 32'(e.psel));
        check("paddr", paddr, e.addr);
        check("pwrite", 32'(pwrite), 32'(e.wr));
        check("pstrb", 32'(pstrb), 32'(e.strb));
        check("pprot", 32'(pprot), 32'(e.prot));
        if (e.wr) check("pwdata", pwdata, e.wdata);
      end
    end
  end

  // R/B monitor: each completed handshake must match the next queued response
  always @(negedge clk) begin
    rsp_t e;
    if (rvalid && rready) begin
      if (r_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: rresp=%b rdata=%h, expected no response", rresp, rdata);
      end else begin
        e = r_q.pop_front();
        check("rresp", 32'(rresp), 32'(e.resp));
        check("rdata", rdata, e.data);
      end
    end
    if (bvalid && bready) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: bresp=%b, expected no response", bresp);
      end else begin
        e = b_q.pop_front();
        check("bresp", 32'(bresp), 32'(e.resp));
      end
    end
  end

  task automatic send_rd(input logic [31:0] a, input logic [2:0] p);
    int n = 0;
    araddr = a; arprot = p; arvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 500);
    check("ar_accept", 32'(n < 500), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input int w_delay);
    int n = 0;
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    awaddr = a; awprot = p; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = (w_delay == 0);
    while (!(aw_done && w_done) && n < 500) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
      if (!w_done && !wvalid && n >= w_delay) wvalid = 1'b1;
    end
    check("wr_accept", 32'(n < 500), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || apb_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_valid", 32'({bvalid, rvalid, penable}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'({awready, wready, arready}), 32'b111);

    // Read 0x1004 with cycle-exact latency
    @(posedge clk); #1;
    exp_apb(4'b0010, 32'h1004, 1'b0, 32'd0, 4'b0000, 3'b101);
    exp_r(2'b00, SD1);
    araddr = 32'h1004; arprot = 3'b101; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk); check("c0_psel", 32'(psel), 32'd0);
    @(negedge clk); check("c1_setup", 32'({psel, penable}), 32'b0010_0);
    @(negedge clk); check("c2_access", 32'({psel, penable}), 32'b0010_1);
    @(negedge clk); check("c3_rvalid", 32'({rvalid, psel}), 32'b1_0000);
    drain();

    // Write with W arriving 3 cycles after AW
    exp_apb(4'b1000, 32'h3008, 1'b1, 32'h1234_5678, 4'b0101, 3'b010);
    exp_b(2'b00);
    fork
      send_wr(32'h3008, 32'h1234_5678, 4'b0101, 3'b010, 3);
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("no_setup_before_w", 32'(psel), 32'd0);
        end
      end
    join
    drain();

    // Simultaneous read and write streams: read first, then alternation
    exp_apb(4'b0001, 32'h0010, 1'b0, 32'd0, 4'b0000, 3'b001);
    exp_apb(4'b1000, 32'h3000, 1'b1, 32'h0000_00AA, 4'b1111, 3'b010);
    exp_apb(4'b0010, 32'h1010, 1'b0, 32'd0, 4'b0000, 3'b001);
    exp_apb(4'b0001, 32'h0020, 1'b1, 32'h0000_00BB, 4'b0011, 3'b010);
    exp_apb(4'b0100, 32'h2010, 1'b0, 32'd0, 4'b0000, 3'b001);
    exp_apb(4'b0010, 32'h1020, 1'b1, 32'h0000_00CC, 4'b1100, 3'b010);
    exp_r(2'b00, SD0); exp_r(2'b00, SD1); exp_r(2'b00, SD2);
    exp_b(2'b00); exp_b(2'b00); exp_b(2'b00);
    fork
      begin
        send_rd(32'h0010, 3'b001);
        send_rd(32'h1010, 3'b001);
        send_rd(32'h2010, 3'b001);
      end
      begin
        send_wr(32'h3000, 32'h0000_00AA, 4'b1111, 3'b010, 0);
        send_wr(32'h0020, 32'h0000_00BB, 4'b0011, 3'b010, 0);
        send_wr(32'h1020, 32'h0000_00CC, 4'b1100, 3'b010, 0);
      end
    join
    drain();

    // Decode errors: no APB activity, DECERR with zero read data
    exp_b(2'b11);
    send_wr(32'h5000, 32'hFFFF_FFFF, 4'b1111, 3'b000, 0);
    drain();
    exp_r(2'b11, 32'd0);
    send_rd(32'h5000, 3'b000);
    drain();

    // Slave error on slave 2; the same error line is ignored for slave 1
    err_mask = 4'b0100;
    exp_apb(4'b0100, 32'h2000, 1'b0, 32'd0, 4'b0000, 3'b000);
    exp_r(2'b10, SD2);
    send_rd(32'h2000, 3'b000);
    drain();
    exp_apb(4'b0010, 32'h1000, 1'b0, 32'd0, 4'b0000, 3'b000);
    exp_r(2'b00, SD1);
    send_rd(32'h1000, 3'b000);
    drain();
    err_mask = 4'b0000;

    // Timeout: 16 ACCESS cycles, then SLVERR with zero data
    ready_delay = 1000;
    exp_apb(4'b0010, 32'h1008, 1'b0, 32'd0, 4'b0000, 3'b000);
    exp_r(2'b10, 32'd0);
    send_rd(32'h1008, 3'b000);
    acc = 0; cyc = 0;
    while (!rvalid && cyc < 200) begin
      @(negedge clk);
      if (penable) acc++;
      cyc++;
    end
    check("timeout_access_cycles", 32'(acc), 32'd16);
    check("timeout_psel_dropped", 32'({psel, penable}), 32'd0);
    drain();

    // pready on the expiry cycle still completes normally
    ready_delay = 15;
    exp_apb(4'b1000, 32'h300C, 1'b0, 32'd0, 4'b0000, 3'b000);
    exp_r(2'b00, SD3);
    send_rd(32'h300C, 3'b000);
    drain();

    // Reset during ACCESS aborts with no response
    ready_delay = 1000;
    exp_apb(4'b0010, 32'h1010, 1'b0, 32'd0, 4'b0000, 3'b000);
    send_rd(32'h1010, 3'b000);
    cyc = 0;
    while (!penable && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_access", 32'(penable), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({psel, penable, rvalid, arready}), 32'd0);
    ready_delay = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_mid_rst", 32'({awready, wready, arready}), 32'b111);
    check("no_resp_after_rst", 32'({rvalid, bvalid}), 32'd0);
    @(posedge clk); #1;
    exp_apb(4'b1000, 32'h3004, 1'b0, 32'd0, 4'b0000, 3'b001);
    exp_r(2'b00, SD3);
    send_rd(32'h3004, 3'b001);
    drain();

    check("apb_q_empty", 32'(apb_q.size()), 32'd0);
    check("r_q_empty", 32'(r_q.size()), 32'd0);
    check("b_q_empty", 32'(b_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
